// File: rtl/reg_dst_scoreboard.sv
// Register-destination decode with a busy bitmap of in-flight writes and RAW/WAW issue stall.
// Optional define REG_DST_WB_BYPASS_EN lets a same-cycle writeback release a hazard.
module reg_dst_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int SEL_W    = 3,
    parameter int SP_IDX   = 29,
    parameter int RA_IDX   = 31,
    parameter int MAX_PEND = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [ADDR_W-1:0]                InstructionRS,
    input  logic [ADDR_W-1:0]                InstructionRT,
    input  logic [ADDR_W-1:0]                InstructionRD,
    input  logic [SEL_W-1:0]                 RegDst,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic                             wr_en_req,
    input  logic                             rs_use,
    input  logic                             rt_use,
    input  logic                             wb_valid,
    input  logic [ADDR_W-1:0]                wb_idx,
    output logic [ADDR_W-1:0]                toWReg,
    output logic                             dst_valid,
    output logic [(2**ADDR_W)-1:0]           busy_map,
    output logic [$clog2(MAX_PEND+1)-1:0]    pend_cnt,
    output logic                             sel_err
);
    localparam int NREG  = 2**ADDR_W;
    localparam int CNT_W = $clog2(MAX_PEND+1);

    logic [ADDR_W-1:0] dst;
    logic              sel_illegal;
    logic [NREG-1:0]   busy_reg, busy_next, busy_eff, wb_mask, set_mask;
    logic [CNT_W-1:0]  pend_reg, pend_next;
    logic [ADDR_W-1:0] towreg_reg;
    logic              dst_valid_reg, sel_err_reg;
    logic              fire, issue_set, wb_clr, wb_spurious, cap_ok;

    always_comb begin
        dst         = '0;
        sel_illegal = 1'b0;
        case (RegDst)
            SEL_W'(0): dst = InstructionRS;
            SEL_W'(1): dst = InstructionRT;
            SEL_W'(2): dst = ADDR_W'(SP_IDX);
            SEL_W'(3): dst = ADDR_W'(RA_IDX);
            SEL_W'(4): dst = InstructionRD;
            default:   sel_illegal = 1'b1;
        endcase
    end

    assign wb_clr      = wb_valid & busy_reg[wb_idx];
    assign wb_spurious = wb_valid & ~busy_reg[wb_idx];

`ifdef REG_DST_WB_BYPASS_EN
    // A writeback landing this cycle already frees its register and its slot.
    assign busy_eff = busy_reg & ~wb_mask;
    assign cap_ok   = (pend_reg < CNT_W'(MAX_PEND)) | wb_clr;
`else
    assign busy_eff = busy_reg;
    assign cap_ok   = (pend_reg < CNT_W'(MAX_PEND));
`endif

    assign issue_ready = !(rs_use && busy_eff[InstructionRS])
                       && !(rt_use && busy_eff[InstructionRT])
                       && !(wr_en_req && busy_eff[dst])
                       && cap_ok;
    assign fire      = issue_valid & issue_ready;
    assign issue_set = fire & wr_en_req & (dst != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign wb_mask[gi]  = wb_valid && (wb_idx == ADDR_W'(gi));
            assign set_mask[gi] = issue_set && (dst == ADDR_W'(gi));
            // Clear before set so a same-index set/clear leaves the bit set.
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_nz
                assign busy_next[gi] = (busy_reg[gi] & ~wb_mask[gi]) | set_mask[gi];
            end
        end
    endgenerate

    assign pend_next = pend_reg + CNT_W'(issue_set) - CNT_W'(wb_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg      <= '0;
            pend_reg      <= '0;
            towreg_reg    <= '0;
            dst_valid_reg <= 1'b0;
            sel_err_reg   <= 1'b0;
        end else begin
            busy_reg      <= busy_next;
            pend_reg      <= pend_next;
            dst_valid_reg <= fire & wr_en_req;
            if (fire)
                towreg_reg <= dst;
            if ((fire && sel_illegal) || wb_spurious)
                sel_err_reg <= 1'b1;
        end
    end

    assign toWReg    = towreg_reg;
    assign dst_valid = dst_valid_reg;
    assign busy_map  = busy_reg;
    assign pend_cnt  = pend_reg;
    assign sel_err   = sel_err_reg;
endmodule

// File: tb/tb_reg_dst_scoreboard.sv
// Bench for reg_dst_scoreboard: directed steps then random traffic against a set-of-pending-writes model.
module tb_reg_dst_scoreboard;
    localparam int ADDR_W = 5, SEL_W = 3, SP_IDX = 29, RA_IDX = 31, MAX_PEND = 4;
    localparam int NREG = 1 << ADDR_W;
    localparam int CW = $clog2(MAX_PEND + 1);

    logic clk = 1'b0, reset_n = 1'b0;
    logic [ADDR_W-1:0] rs = '0, rt = '0, rd = '0, wb_idx = '0;
    logic [SEL_W-1:0] regdst = '0;
    logic issue_valid = 0, wr_en_req = 0, rs_use = 0, rt_use = 0, wb_valid = 0;
    logic issue_ready, dst_valid, sel_err;
    logic [ADDR_W-1:0] towreg;
    logic [NREG-1:0] busy_map;
    logic [CW-1:0] pend_cnt;

    reg_dst_scoreboard #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .SP_IDX(SP_IDX),
                         .RA_IDX(RA_IDX), .MAX_PEND(MAX_PEND)) dut (
        .clk(clk), .reset_n(reset_n),
        .InstructionRS(rs), .InstructionRT(rt), .InstructionRD(rd),
        .RegDst(regdst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .wr_en_req(wr_en_req), .rs_use(rs_use), .rt_use(rt_use),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .toWReg(towreg),
        .dst_valid(dst_valid), .busy_map(busy_map), .pend_cnt(pend_cnt),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    // Model: the set of registers with a write outstanding, plus last issue result.
    bit m_pending[NREG];
    int m_tow = 0, m_dv = 0, m_err = 0;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) if (m_pending[i]) n++;
        return n;
    endfunction

    function automatic logic [NREG-1:0] m_map();
        logic [NREG-1:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_pending[i];
        return v;
    endfunction

    function automatic int m_dst();
        case (int'(regdst))
            0: return int'(rs);
            1: return int'(rt);
            2: return SP_IDX;
            3: return RA_IDX;
            4: return int'(rd);
            default: return 0;
        endcase
    endfunction

    function automatic bit m_waiting(int r);
        if (r == 0 || !m_pending[r]) return 0;
`ifdef REG_DST_WB_BYPASS_EN
        if (wb_valid && int'(wb_idx) == r) return 0;
`endif
        return 1;
    endfunction

    function automatic bit m_ready();
        bit room = (m_count() < MAX_PEND);
`ifdef REG_DST_WB_BYPASS_EN
        if (wb_valid && m_pending[wb_idx]) room = 1;
`endif
        if (rs_use && m_waiting(int'(rs))) return 0;
        if (rt_use && m_waiting(int'(rt))) return 0;
        if (wr_en_req && m_waiting(m_dst())) return 0;
        return room;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int s, int t, int d, int sel, bit iv, bit wr, bit ru, bit tu, bit wv, int wi);
        rs = ADDR_W'(s); rt = ADDR_W'(t); rd = ADDR_W'(d); regdst = SEL_W'(sel);
        issue_valid = iv; wr_en_req = wr; rs_use = ru; rt_use = tu;
        wb_valid = wv; wb_idx = ADDR_W'(wi);
    endtask

    // Inputs are driven just after a negedge; ready is checked before the edge,
    // registered outputs at the following negedge.
    task automatic step(string tag);
        bit exp_r, fire;
        int d;
        #1;
        exp_r = m_ready();
        chk({tag, ".ready"}, 64'(issue_ready), 64'(exp_r));
        fire = issue_valid && exp_r;
        d = m_dst();
        @(posedge clk);
        if (wb_valid) begin
            if (m_pending[wb_idx]) m_pending[wb_idx] = 0;
            else m_err = 1;
        end
        m_dv = 0;
        if (fire) begin
            m_tow = d;
            m_dv = wr_en_req;
            if (wr_en_req && d != 0) m_pending[d] = 1;
            if (regdst > 4) m_err = 1;
        end
        @(negedge clk);
        chk({tag, ".toWReg"}, 64'(towreg), 64'(m_tow));
        chk({tag, ".dst_valid"}, 64'(dst_valid), 64'(m_dv));
        chk({tag, ".busy_map"}, 64'(busy_map), 64'(m_map()));
        chk({tag, ".pend_cnt"}, 64'(pend_cnt), 64'(m_count()));
        chk({tag, ".sel_err"}, 64'(sel_err), 64'(m_err));
        $display("txn %s sel=%0d iv=%0d wb=%0d/%0d ready=%0d toWReg=%0d busy=%h cnt=%0d err=%0d",
                 tag, regdst, issue_valid, wb_valid, wb_idx, issue_ready, towreg, busy_map, pend_cnt, sel_err);
    endtask

    task automatic drain();
        for (int i = 1; i < NREG; i++) begin
            if (m_pending[i]) begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 1, i);
                step("drain");
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2;
        chk("rst.toWReg", 64'(towreg), 64'd0);
        chk("rst.dst_valid", 64'(dst_valid), 64'd0);
        chk("rst.busy_map", 64'(busy_map), 64'd0);
        chk("rst.pend_cnt", 64'(pend_cnt), 64'd0);
        chk("rst.sel_err", 64'(sel_err), 64'd0);
        @(negedge clk); reset_n = 1;
        @(negedge clk);

        drive(0, 0, 8, 4, 1, 1, 0, 0, 0, 0); step("iss_rd8");
        chk("iss_rd8.const_to", 64'(towreg), 64'd8);
        chk("iss_rd8.const_busy", 64'(busy_map), 64'h100);
        chk("iss_rd8.const_cnt", 64'(pend_cnt), 64'd1);

        drive(8, 0, 9, 4, 1, 1, 1, 0, 0, 0); step("raw_blk0");
        step("raw_blk1");
        drive(8, 0, 9, 4, 1, 1, 1, 0, 1, 8); step("raw_wb");
        drive(8, 0, 9, 4, 1, 1, 1, 0, 0, 0); step("raw_after");
        drain();

        drive(0, 0, 0, 2, 1, 1, 0, 0, 0, 0); step("sp");
        chk("sp.const_to", 64'(towreg), 64'd29);
        drive(0, 0, 0, 3, 1, 1, 0, 0, 0, 0); step("ra");
        chk("ra.const_to", 64'(towreg), 64'd31);
        chk("ra.const_cnt", 64'(pend_cnt), 64'd2);
        drive(0, 0, 10, 4, 1, 1, 0, 0, 0, 0); step("fill3");
        drive(0, 0, 11, 4, 1, 1, 0, 0, 0, 0); step("fill4");
        drive(0, 0, 12, 4, 1, 1, 0, 0, 0, 0); #1;
        chk("full.const_ready", 64'(issue_ready), 64'd0);
        step("full");
        drain();

        drive(0, 0, 7, 6, 1, 1, 0, 0, 0, 0); step("illegal");
        chk("illegal.const_err", 64'(sel_err), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5); step("spurious_wb");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("err_sticky");

        drive(0, 0, 8, 4, 1, 1, 0, 0, 0, 0); step("same_a");
        drive(0, 0, 3, 4, 1, 1, 0, 0, 1, 8); step("same_b");
        chk("same.const_busy", 64'(busy_map), 64'h8);
        chk("same.const_cnt", 64'(pend_cnt), 64'd1);
        drain();

        for (int n = 0; n < 300; n++) begin
            int sel = ($urandom_range(0, 15) > 13) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), sel,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7));
            step("rand");
        end
        drain();

        drive(0, 0, 4, 4, 1, 1, 0, 0, 0, 0); step("pre_a");
        drive(0, 0, 5, 4, 1, 1, 0, 0, 0, 0); step("pre_b");
        drive(0, 0, 6, 4, 1, 1, 0, 0, 0, 0); step("pre_c");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        reset_n = 0; #1;
        chk("arst.toWReg", 64'(towreg), 64'd0);
        chk("arst.dst_valid", 64'(dst_valid), 64'd0);
        chk("arst.busy_map", 64'(busy_map), 64'd0);
        chk("arst.pend_cnt", 64'(pend_cnt), 64'd0);
        chk("arst.sel_err", 64'(sel_err), 64'd0);
        for (int i = 0; i < NREG; i++) m_pending[i] = 0;
        m_tow = 0; m_dv = 0; m_err = 0;
        @(negedge clk); reset_n = 1;
        drive(0, 0, 4, 4, 1, 1, 1, 0, 0, 0); #1;
        chk("arst.const_ready", 64'(issue_ready), 64'd1);
        step("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
